s_seg_capture: RTL and testbench

- Receive-side counterpart of the hex-to-seven-segment encoder: snoops a multiplexed, active-low seven-segment display bus (segment lines plus one-hot active-low digit selects) and reconstructs the displayed hex digits.
- Requires each {select, segment} pattern to be stable before accepting it, decodes it back to a 4-bit value with error and blank flags, and keeps a per-digit register file.
- Emits change events on a valid/ready output port.
- Used by board-level self-check and scoreboard logic alongside the display path.

---
 rtl/s_seg_pkg.sv | 64 ++++++
 rtl/s_seg_decode.sv | 19 +
 rtl/s_seg_capture.sv | 201 ++++++++++++++++++++
 tb/tb_s_seg_capture.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_seg_pkg.sv
// Shared definitions for the seven-segment capture path: segment codes,
// FSM encoding and the pattern-to-value decode function.
package s_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] value;
  } seg_dec_t;

  localparam seg_dec_t DEC_BLANK = '{err: 1'b0, blank: 1'b1, value: 4'h0};

  // value stays 0 whenever err or blank is reported
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t d;
    d = '0;
    case (seg)
      SEG_0:     d.value = 4'h0;
      SEG_1:     d.value = 4'h1;
      SEG_2:     d.value = 4'h2;
      SEG_3:     d.value = 4'h3;
      SEG_4:     d.value = 4'h4;
      SEG_5:     d.value = 4'h5;
      SEG_6:     d.value = 4'h6;
      SEG_7:     d.value = 4'h7;
      SEG_8:     d.value = 4'h8;
      SEG_9:     d.value = 4'h9;
      SEG_A:     d.value = 4'hA;
      SEG_B:     d.value = 4'hB;
      SEG_C:     d.value = 4'hC;
      SEG_D:     d.value = 4'hD;
      SEG_E:     d.value = 4'hE;
      SEG_F:     d.value = 4'hF;
      SEG_BLANK: d.blank = 1'b1;
      default:   d.err   = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/s_seg_decode.sv
// Combinational active-low segment pattern decoder, reusable by other
// display-bus checkers.
module s_seg_decode
  import s_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       err,
  output logic       blank,
  output logic [3:0] value
);

  seg_dec_t d;

  assign d     = seg_decode(seg);
  assign err   = d.err;
  assign blank = d.blank;
  assign value = d.value;

endmodule

// File: rtl/s_seg_capture.sv
// Snoops a multiplexed active-low seven-segment bus, captures stable
// patterns per digit and reports changes on a valid/ready event port.
module s_seg_capture
  import s_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   sel_in,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_digit,
  output logic [3:0]              out_value,
  output logic                    out_err,
  output logic                    out_blank,
  output logic                    overflow
);

  localparam int KW = NUM_DIGITS + 7;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [KW-1:0]         sync1_reg, sync2_reg, prev_key_reg;
  logic [NUM_DIGITS-1:0] key_sel;
  logic [6:0]            key_seg;
  logic                  sel_legal;
  logic [IW-1:0]         sel_idx;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       capture;

  seg_dec_t   dec;
  logic       dec_err, dec_blank;
  logic [3:0] dec_value;
  seg_dec_t   last_arr [NUM_DIGITS];
  logic       ev, ev_load;

  logic       out_valid_reg, out_err_reg, out_blank_reg, overflow_reg;
  logic [2:0] out_digit_reg;
  logic [3:0] out_value_reg;

  assign key_sel = sync2_reg[KW-1:7];
  assign key_seg = sync2_reg[6:0];

  // prev_key keeps loading through clear so a held pattern is not re-tracked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg    <= '1;
      sync2_reg    <= '1;
      prev_key_reg <= '1;
    end else begin
      sync1_reg    <= {sel_in, seg_in};
      sync2_reg    <= sync1_reg;
      prev_key_reg <= sync2_reg;
    end
  end

  always_comb begin
    sel_legal = $onehot(~key_sel);
    sel_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!key_sel[i]) sel_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    if (!sel_legal) begin
      state_next = IDLE;
      cnt_next   = 8'd0;
    end else if (sync2_reg != prev_key_reg) begin
      cnt_next = 8'd1;
      if (STABLE_CYCLES == 1) begin
        capture    = 1'b1;
        state_next = HELD;
      end else begin
        state_next = TRACK;
      end
    end else begin
      case (state_reg)
        TRACK: begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_next == 8'(STABLE_CYCLES)) begin
            capture    = 1'b1;
            state_next = HELD;
          end
        end
        HELD: begin
          if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
        end
        default: ;
      endcase
    end
    if (clear) begin
      state_next = IDLE;
      cnt_next   = 8'd0;
      capture    = 1'b0;
    end
  end

  s_seg_decode u_decode (
    .seg   (key_seg),
    .err   (dec_err),
    .blank (dec_blank),
    .value (dec_value)
  );

  assign dec     = {dec_err, dec_blank, dec_value};
  assign ev      = capture && (dec != last_arr[sel_idx]);
  assign ev_load = ev && (!out_valid_reg || out_ready);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] value_reg;
    logic       valid_reg;
    seg_dec_t   last_reg;
    logic       hit;

    assign hit = capture && !key_sel[gi];

    // a dropped event leaves last_reg stale so the digit gets re-reported
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        value_reg <= 4'h0;
        valid_reg <= 1'b0;
        last_reg  <= DEC_BLANK;
      end else if (clear) begin
        value_reg <= 4'h0;
        valid_reg <= 1'b0;
        last_reg  <= DEC_BLANK;
      end else if (hit) begin
        if (!dec.err && !dec.blank) begin
          value_reg <= dec.value;
          valid_reg <= 1'b1;
        end else begin
          valid_reg <= 1'b0;
        end
        if (ev_load) last_reg <= dec;
      end
    end

    assign digits_out[4*gi +: 4] = value_reg;
    assign digit_valid[gi]       = valid_reg;
    assign last_arr[gi]          = last_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_digit_reg <= 3'd0;
      out_value_reg <= 4'h0;
      out_err_reg   <= 1'b0;
      out_blank_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (clear) begin
      out_valid_reg <= 1'b0;
      out_digit_reg <= 3'd0;
      out_value_reg <= 4'h0;
      out_err_reg   <= 1'b0;
      out_blank_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (ev) begin
      if (ev_load) begin
        out_valid_reg <= 1'b1;
        out_digit_reg <= 3'(sel_idx);
        out_value_reg <= dec.value;
        out_err_reg   <= dec.err;
        out_blank_reg <= dec.blank;
      end else begin
        overflow_reg  <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_digit = out_digit_reg;
  assign out_value = out_value_reg;
  assign out_err   = out_err_reg;
  assign out_blank = out_blank_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_s_seg_capture.sv
// Directed plus randomized bench for s_seg_capture, checked every cycle
// against a pin-history reference model.
module tb_s_seg_capture;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] SCAN [4] = '{7'h0E, 7'h21, 7'h46, 7'h08};

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic [6:0]      seg_in    = 7'h7F;
  logic [ND-1:0]   sel_in    = '1;
  logic            clear     = 1'b0;
  logic            out_ready = 1'b0;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0]   digit_valid;
  logic            out_valid;
  logic [2:0]      out_digit;
  logic [3:0]      out_value;
  logic            out_err;
  logic            out_blank;
  logic            overflow;

  s_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .sel_in      (sel_in),
    .clear       (clear),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_digit   (out_digit),
    .out_value   (out_value),
    .out_err     (out_err),
    .out_blank   (out_blank),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pins seen at each edge, clear flags, and architectural results
  logic [ND+6:0] hist [$];
  bit            clr_hist [$];
  logic [3:0]    m_digits [ND];
  logic [5:0]    m_last [ND];
  logic [ND-1:0] m_dvalid;
  logic          m_valid, m_ov, m_err, m_blank;
  logic [2:0]    m_digit;
  logic [3:0]    m_value;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < ND; i++) begin
      m_digits[i] = 4'h0;
      m_last[i]   = 6'h10;
    end
    m_dvalid = '0;
    m_valid  = 1'b0;
    m_ov     = 1'b0;
    m_err    = 1'b0;
    m_blank  = 1'b0;
    m_digit  = 3'd0;
    m_value  = 4'h0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    clr_hist.delete();
    for (int i = 0; i < 3; i++) begin
      hist.push_back('1);
      clr_hist.push_back(1'b0);
    end
    model_clear();
  endfunction

  // A capture happens when a freshly changed legal key has been seen for
  // exactly SC edges (two edges of synchronizer delay) with no clear meanwhile.
  function automatic void model_step(input logic [6:0] sg, input logic [ND-1:0] sl,
                                     input logic clr, input logic rdy);
    logic [ND+6:0] k;
    int            j, s, run, d, zeros;
    logic          cap, ev, found, bl, er;
    logic [3:0]    v;
    logic [5:0]    rep;
    hist.push_back({sl, sg});
    clr_hist.push_back(clr);
    j     = hist.size() - 1;
    k     = hist[j-2];
    zeros = 0;
    d     = 0;
    for (int i = 0; i < ND; i++) begin
      if (!k[7+i]) begin
        zeros++;
        d = i;
      end
    end
    cap = 1'b0;
    if (zeros == 1) begin
      s = j - 2;
      while (s > 0 && hist[s-1] == k && (j - 1 - s) <= SC) s--;
      run = j - 1 - s;
      if (s > 0 && hist[s-1] != k && run == SC) begin
        cap = 1'b1;
        for (int e = s + 2; e <= j; e++) if (clr_hist[e]) cap = 1'b0;
      end
    end
    if (clr) begin
      model_clear();
    end else begin
      ev    = 1'b0;
      found = 1'b0;
      v     = 4'h0;
      bl    = 1'b0;
      er    = 1'b0;
      if (cap) begin
        for (int c = 0; c < 16; c++) begin
          if (CODES[c] == k[6:0]) begin
            found = 1'b1;
            v     = 4'(c);
          end
        end
        bl = (k[6:0] == 7'h7F);
        er = !found && !bl;
        if (found) begin
          m_digits[d] = v;
          m_dvalid[d] = 1'b1;
        end else begin
          m_dvalid[d] = 1'b0;
        end
        rep = {er, bl, v};
        ev  = (rep != m_last[d]);
      end
      if (ev) begin
        if (!m_valid || rdy) begin
          m_valid   = 1'b1;
          m_digit   = 3'(d);
          m_value   = v;
          m_err     = er;
          m_blank   = bl;
          m_last[d] = {er, bl, v};
        end else begin
          m_ov = 1'b1;
        end
      end else if (rdy) begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic check_all();
    logic [4*ND-1:0] ed;
    for (int i = 0; i < ND; i++) ed[4*i +: 4] = m_digits[i];
    chk("out_valid",   32'(out_valid),   32'(m_valid));
    chk("out_digit",   32'(out_digit),   32'(m_digit));
    chk("out_value",   32'(out_value),   32'(m_value));
    chk("out_err",     32'(out_err),     32'(m_err));
    chk("out_blank",   32'(out_blank),   32'(m_blank));
    chk("overflow",    32'(overflow),    32'(m_ov));
    chk("digits_out",  32'(digits_out),  32'(ed));
    chk("digit_valid", 32'(digit_valid), 32'(m_dvalid));
  endtask

  task automatic step(input logic [6:0] sg, input logic [ND-1:0] sl, input logic clr, input logic rdy);
    @(negedge clk);
    seg_in    = sg;
    sel_in    = sl;
    clear     = clr;
    out_ready = rdy;
    @(posedge clk);
    model_step(sg, sl, clr, rdy);
    #1;
    check_all();
    $display("[TB] t=%0t sel=%b seg=%h clr=%0d rdy=%0d -> valid=%0d digit=%0d value=%h err=%0d blank=%0d ovf=%0d digits=%h",
             $time, sl, sg, clr, rdy, out_valid, out_digit, out_value, out_err, out_blank, overflow, digits_out);
  endtask

  function automatic logic [ND-1:0] sel_of(input int d);
    logic [ND-1:0] s;
    s    = '1;
    s[d] = 1'b0;
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_digits", 32'(digits_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int            ev_count;
    logic [ND-1:0] sl;
    logic [6:0]    sg;
    int            r, n;

    #2;
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);

    // single digit capture latency
    repeat (2) step(7'h7F, '1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(7'h24, 4'b1110, 1'b0, 1'b0);
      if (i == 4) chk("lat_early", 32'(out_valid), 32'd0);
      if (i == 5) chk("lat_valid", 32'(out_valid), 32'd1);
    end
    chk("first_digit", 32'(out_digit), 32'd0);
    chk("first_value", 32'(out_value), 32'd2);
    chk("first_dvalid", 32'(digit_valid), 32'b0001);
    step(7'h24, 4'b1110, 1'b0, 1'b1);

    // two full scans: only the first produces events
    for (int pass = 0; pass < 2; pass++) begin
      ev_count = 0;
      for (int dd = 3; dd >= 0; dd--) begin
        for (int i = 0; i < 8; i++) begin
          step(SCAN[3-dd], sel_of(dd), 1'b0, 1'b1);
          if (out_valid) ev_count++;
        end
      end
      chk("scan_events", 32'(ev_count), (pass == 0) ? 32'd4 : 32'd0);
    end
    chk("scan_digits", 32'(digits_out), 32'hFDCA);

    // illegal pattern then blank on digit 1
    for (int i = 0; i < 8; i++) begin
      step(7'h55, 4'b1101, 1'b0, 1'b1);
      if (i == 5) chk("err_flag", 32'(out_err), 32'd1);
    end
    chk("err_dvalid", 32'(digit_valid[1]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(7'h7F, 4'b1101, 1'b0, 1'b1);
      if (i == 5) chk("blank_flag", 32'(out_blank), 32'd1);
    end

    // back-pressure: second event dropped, later re-reported
    for (int i = 0; i < 8; i++) step(7'h02, 4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(7'h79, 4'b0111, 1'b0, 1'b0);
    chk("hold_digit", 32'(out_digit), 32'd2);
    chk("hold_value", 32'(out_value), 32'd6);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) step(7'h08, 4'b1110, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(7'h79, 4'b0111, 1'b0, 1'b1);
      if (i == 5) chk("rereport", 32'({out_valid, out_digit, out_value}), 32'({1'b1, 3'd3, 4'h1}));
    end

    // glitching segments, then an illegal select
    for (int i = 0; i < 16; i++) begin
      step(((i / 2) % 2 != 0) ? 7'h19 : 7'h12, 4'b1110, 1'b0, 1'b1);
      chk("glitch_quiet", 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      step(7'h30, 4'b1100, 1'b0, 1'b1);
      chk("illegal_quiet", 32'(out_valid), 32'd0);
    end

    // reset in the middle of tracking
    for (int i = 0; i < 3; i++) step(7'h19, 4'b1011, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(7'h7F, '1, 1'b0, 1'b0);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < 8; i++) step(7'h19, 4'b1011, 1'b0, 1'b0);
    chk("post_rst_event", 32'(out_value), 32'd4);

    // clear while an event is pending, with the pattern still held
    step(7'h19, 4'b1011, 1'b1, 1'b0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) step(7'h19, 4'b1011, 1'b0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 120; t++) begin
      r  = int'($urandom_range(0, 15));
      sl = sel_of(int'($urandom_range(0, ND - 1)));
      if (r == 0) sl = ND'($urandom);
      sg = CODES[$urandom_range(0, 15)];
      if (r == 1) sg = 7'h7F;
      if (r == 2) sg = 7'($urandom);
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) step(sg, sl, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
